// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: default field widths and
// control-field bit positions, plus the skid-buffer occupancy encoding.
package pipe_pkg;

    localparam int CTRL_W_DEF = 10;
    localparam int DATA_W_DEF = 149;
    localparam int CNT_W_DEF  = 16;

    // Control-field bit positions; bit 9 is spare in the default 10-bit field.
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_READ  = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALU_SRC   = 5;
    localparam int CTRL_REG_DST   = 6;
    localparam int CTRL_ALU_OP_LO = 7;
    localparam int CTRL_ALU_OP_HI = 8;
    localparam int CTRL_SPARE     = 9;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_MAIN  = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) storage for pipe_stage_reg; in_ready is a flop so
// there is no combinational path from out_ready to in_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    buf_state_e        state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic              accept;
    logic              release_main;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        accept       = in_valid && in_ready_q;
        release_main = (state_q != BUF_EMPTY) && out_ready;

        if (flush) begin
            state_d     = BUF_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d     = BUF_MAIN;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                BUF_MAIN: begin
                    if (release_main && accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (release_main) begin
                        state_d     = BUF_EMPTY;
                        main_ctrl_d = '0;
                    end else if (accept) begin
                        state_d     = BUF_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                end
                BUF_FULL: begin
                    // in_ready is low here, so only the skid-to-main move can happen.
                    if (release_main) begin
                        state_d     = BUF_MAIN;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = BUF_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BUF_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with valid/ready handshake, flush and bubble counter.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid-buffer variant.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

`ifdef PIPE_STAGE_SKID_EN

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

`else

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;
    logic              release_entry;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;

        accept        = in_valid && in_ready;
        release_entry = valid_q && out_ready;

        // Flush wins over a same-cycle accept; data is kept, control is zeroed.
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
        end else if (release_entry) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = out_ready || !valid_q;
    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;

`endif

    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counts downstream-idle cycles; flush does not touch it.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule
